// File: rtl/act_feeder_row.sv
// Activation feeder: one upstream row-tagged stream split into per-row FIFOs,
// each drained one word per cycle while its superblock holds request high.
module act_feeder_row #(
    parameter int N_ROW      = 7,
    parameter int WID_ACT    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int WID_ROW    = $clog2(N_ROW)
) (
    input  logic                         clk_l,
    input  logic                         rst_n,
    input  logic [2*WID_ACT-1:0]         s_data,
    input  logic [WID_ROW-1:0]           s_row,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [N_ROW-1:0]             act_data_in_req,
    output logic [2*WID_ACT*N_ROW-1:0]   act_data_in,
    output logic [N_ROW-1:0]             act_data_in_vld,
    output logic [N_ROW-1:0]             row_empty,
    output logic                         err_row
);

    localparam int W  = 2 * WID_ACT;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [WID_ROW:0] NROW_L  = (WID_ROW + 1)'(N_ROW);
    localparam logic [PW:0]      PTR_ONE = (PW + 1)'(1);

    logic [W-1:0]     mem_q  [N_ROW][FIFO_DEPTH];
    logic [PW:0]      wr_q   [N_ROW];
    logic [PW:0]      wr_d   [N_ROW];
    logic [PW:0]      rd_q   [N_ROW];
    logic [PW:0]      rd_d   [N_ROW];
    logic [W-1:0]     dout_q [N_ROW];
    logic [W-1:0]     dout_d [N_ROW];
    logic [N_ROW-1:0] vld_q, vld_d;
    logic [N_ROW-1:0] full, empty;
    logic [N_ROW-1:0] push_r, pop_r;
    logic             err_q, err_d;
    logic             row_ok, sel_full, push;

    // Extra pointer MSB distinguishes full from empty when indices match.
    always_comb begin
        for (int r = 0; r < N_ROW; r++) begin
            full[r]  = (wr_q[r][PW] != rd_q[r][PW]) &&
                       (wr_q[r][PW-1:0] == rd_q[r][PW-1:0]);
            empty[r] = (wr_q[r] == rd_q[r]);
        end
    end

    always_comb begin
        row_ok   = ({1'b0, s_row} < NROW_L);
        sel_full = 1'b0;
        for (int r = 0; r < N_ROW; r++) begin
            if (s_row == WID_ROW'(r)) sel_full = full[r];
        end
        s_ready = !row_ok || !sel_full;
        push    = s_valid && s_ready && row_ok;
        err_d   = err_q || (s_valid && !row_ok);
    end

    always_comb begin
        for (int r = 0; r < N_ROW; r++) begin
            push_r[r] = push && (s_row == WID_ROW'(r));
            pop_r[r]  = act_data_in_req[r] && !empty[r];
            wr_d[r]   = push_r[r] ? wr_q[r] + PTR_ONE : wr_q[r];
            rd_d[r]   = pop_r[r] ? rd_q[r] + PTR_ONE : rd_q[r];
            vld_d[r]  = pop_r[r];
            dout_d[r] = pop_r[r] ? mem_q[r][rd_q[r][PW-1:0]] : dout_q[r];
        end
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N_ROW; r++) begin
                wr_q[r]   <= '0;
                rd_q[r]   <= '0;
                dout_q[r] <= '0;
            end
            vld_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < N_ROW; r++) begin
                wr_q[r]   <= wr_d[r];
                rd_q[r]   <= rd_d[r];
                dout_q[r] <= dout_d[r];
            end
            vld_q <= vld_d;
            err_q <= err_d;
        end
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clk_l) begin
        for (int r = 0; r < N_ROW; r++) begin
            if (push_r[r]) mem_q[r][wr_q[r][PW-1:0]] <= s_data;
        end
    end

    always_comb begin
        for (int r = 0; r < N_ROW; r++) begin
            act_data_in[r*W +: W] = dout_q[r];
        end
    end

    assign act_data_in_vld = vld_q;
    assign row_empty       = empty;
    assign err_row         = err_q;

endmodule

// File: tb/tb_act_feeder_row.sv
// Bench for act_feeder_row: stimulus table with per-row scoreboard queues
// plus a hand-written mid-stream reset sequence.
module tb_act_feeder_row;

    localparam int NR = 7;
    localparam int W  = 32;

    logic            clk_l;
    logic            rst_n;
    logic [W-1:0]    s_data;
    logic [2:0]      s_row;
    logic            s_valid;
    logic            s_ready;
    logic [NR-1:0]   act_data_in_req;
    logic [W*NR-1:0] act_data_in;
    logic [NR-1:0]   act_data_in_vld;
    logic [NR-1:0]   row_empty;
    logic            err_row;

    act_feeder_row #(
        .N_ROW(7),
        .WID_ACT(16),
        .FIFO_DEPTH(4),
        .WID_ROW(3)
    ) dut (
        .clk_l(clk_l),
        .rst_n(rst_n),
        .s_data(s_data),
        .s_row(s_row),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .act_data_in_req(act_data_in_req),
        .act_data_in(act_data_in),
        .act_data_in_vld(act_data_in_vld),
        .row_empty(row_empty),
        .err_row(err_row)
    );

    initial clk_l = 1'b0;
    always #5 clk_l = ~clk_l;

    typedef struct {
        logic          vld;
        logic [2:0]    row;
        logic [W-1:0]  data;
        logic [NR-1:0] req;
        logic          rdy;
    } vec_t;

    vec_t         tbl[$];
    logic [W-1:0] mq[NR][$];
    logic [W-1:0] last[NR];
    logic         m_err;
    int           n_chk;
    int           n_fail;

    function automatic vec_t mk(input logic v, input logic [2:0] row,
                                input logic [W-1:0] d,
                                input logic [NR-1:0] req,
                                input logic rdy);
        vec_t e;
        e.vld  = v;
        e.row  = row;
        e.data = d;
        e.req  = req;
        e.rdy  = rdy;
        return e;
    endfunction

    function automatic void add(input logic v, input logic [2:0] row,
                                input logic [W-1:0] d,
                                input logic [NR-1:0] req,
                                input logic rdy);
        tbl.push_back(mk(v, row, d, req, rdy));
    endfunction

    task automatic check(input string nm, input logic [255:0] got,
                         input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [W*NR-1:0] ed;
        logic [NR-1:0]   ev;
        for (int r = 0; r < NR; r++) begin
            ed[r*W +: W] = last[r];
            ev[r]        = (mq[r].size() == 0);
        end
        check("data", 256'(act_data_in), 256'(ed));
        check("row_empty", 256'(row_empty), 256'(ev));
        check("err_row", 256'(err_row), 256'(m_err));
    endtask

    task automatic apply(input vec_t v);
        logic          m_rdy;
        logic          acc;
        logic [NR-1:0] pv;
        s_valid         = v.vld;
        s_row           = v.row;
        s_data          = v.data;
        act_data_in_req = v.req;
        #1;
        if (v.row >= 3'(NR)) m_rdy = 1'b1;
        else m_rdy = (mq[v.row].size() < 4);
        check("s_ready", 256'(s_ready), 256'(v.rdy));
        acc = v.vld && m_rdy;
        for (int r = 0; r < NR; r++)
            pv[r] = v.req[r] && (mq[r].size() != 0);
        @(posedge clk_l);
        #1;
        for (int r = 0; r < NR; r++) begin
            if (act_data_in_vld[r]) begin
                if (mq[r].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_underflow row %0d: got vld 1 want 0", r);
                end else begin
                    last[r] = mq[r].pop_front();
                end
            end
        end
        if (acc) begin
            if (v.row < 3'(NR)) mq[v.row].push_back(v.data);
            else m_err = 1'b1;
        end
        check("vld", 256'(act_data_in_vld), 256'(pv));
        check_outputs();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        m_err  = 1'b0;
        for (int r = 0; r < NR; r++) last[r] = '0;

        // T1: two words to row 2, req held
        add(1, 2, 32'h0001_0002, 7'b0000000, 1);
        add(1, 2, 32'h0003_0004, 7'b0000100, 1);
        add(0, 0, 32'h0,         7'b0000100, 1);
        add(0, 0, 32'h0,         7'b0000100, 1);
        add(0, 0, 32'h0,         7'b0000000, 1);
        // T2: fill row 0, backpressure, single-cycle pop
        for (int k = 0; k < 4; k++)
            add(1, 0, 32'hA000_0000 + k, 7'b0, 1);
        add(1, 0, 32'hA000_00FF, 7'b0000000, 0);
        add(0, 1, 32'h0,         7'b0000000, 1);
        add(0, 0, 32'h0,         7'b0000001, 0);
        add(0, 0, 32'h0,         7'b0000000, 1);
        add(0, 0, 32'h0,         7'b0000000, 1);
        for (int k = 0; k < 3; k++) add(0, 0, 32'h0, 7'b0000001, 1);
        add(0, 0, 32'h0, 7'b0000000, 1);
        // T3: row 5 full with same-cycle pop, then streaming across wrap
        for (int k = 1; k <= 4; k++)
            add(1, 5, 32'hB000_0000 + k, 7'b0, 1);
        add(1, 5, 32'hB000_0005, 7'b0100000, 0);
        for (int k = 5; k <= 12; k++)
            add(1, 5, 32'hB000_0000 + k, 7'b0100000, 1);
        for (int k = 0; k < 4; k++) add(0, 5, 32'h0, 7'b0100000, 1);
        add(0, 0, 32'h0, 7'b0, 1);
        // T4: out-of-range row tag
        add(1, 7, 32'hDEAD_BEEF, 7'b0, 1);
        add(0, 7, 32'h0,         7'b0, 1);
        // T5: all rows requesting, round-robin pushes
        for (int k = 0; k < 14; k++)
            add(1, 3'(k % 7), 32'h5000_0000 + k, 7'h7F, 1);
        add(0, 0, 32'h0, 7'h7F, 1);
        add(0, 0, 32'h0, 7'h7F, 1);
        for (int k = 0; k < 7; k++)
            add(1, 3'(k), 32'h6000_0000 + k, 7'h00, 1);

        rst_n           = 1'b0;
        s_valid         = 1'b0;
        s_row           = '0;
        s_data          = '0;
        act_data_in_req = '0;
        repeat (2) @(posedge clk_l);
        #1;
        check("rst_vld", 256'(act_data_in_vld), 256'(0));
        check("rst_ready", 256'(s_ready), 256'(1));
        check_outputs();
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Mid-stream reset with words buffered in every row
        rst_n = 1'b0;
        #1;
        for (int r = 0; r < NR; r++) begin
            mq[r].delete();
            last[r] = '0;
        end
        m_err = 1'b0;
        check("mid_rst_vld", 256'(act_data_in_vld), 256'(0));
        check("mid_rst_ready", 256'(s_ready), 256'(1));
        check_outputs();
        @(posedge clk_l);
        #1;
        rst_n = 1'b1;
        apply(mk(1, 3, 32'h7777_0003, 7'b0000000, 1));
        apply(mk(0, 3, 32'h0,         7'b0001000, 1));
        apply(mk(0, 0, 32'h0,         7'b0000000, 1));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
